// File: rtl/panda_risc_v_inst_buf.sv
// Instruction buffer between fetch and decode. It is a first-word fall-through FIFO
// with a wrap-bit pointer pair and a single-cycle flush for redirects.
module panda_risc_v_inst_buf #(
  parameter int inst_buf_depth   = 4,
  parameter int simulation_delay = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_req,
  input  logic [127:0] s_if_res_data,
  input  logic [3:0]   s_if_res_msg,
  input  logic         s_if_res_valid,
  output logic         s_if_res_ready,
  output logic [127:0] m_inst_data,
  output logic [3:0]   m_inst_msg,
  output logic         m_inst_valid,
  input  logic         m_inst_ready,
  output logic [4:0]   inst_buf_cnt,
  output logic         inst_buf_empty,
  output logic         inst_buf_full
);

  localparam int unsigned AW = $clog2(inst_buf_depth);

  if (inst_buf_depth < 2 || inst_buf_depth > 16 ||
      (inst_buf_depth & (inst_buf_depth - 1)) != 0 || simulation_delay < 0) begin : g_param_check
    $error("panda_risc_v_inst_buf: inst_buf_depth must be a power of 2 in 2..16");
  end

  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic [AW:0]  ptr_diff;
  logic [131:0] mem_q [inst_buf_depth];
  logic         full, empty, push, pop;

  assign empty    = (wptr_q == rptr_q);
  assign full     = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
  assign ptr_diff = wptr_q - rptr_q;

  assign s_if_res_ready = ~full;
  assign m_inst_valid   = ~empty;
  assign inst_buf_cnt   = 5'(ptr_diff);
  assign inst_buf_empty = empty;
  assign inst_buf_full  = full;

  // The head word is gated to zero when empty, so the outputs read as zero out of
  // reset even though the storage array itself is never reset.
  assign {m_inst_data, m_inst_msg} = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    push   = s_if_res_valid & ~full & ~flush_req;
    pop    = ~empty & m_inst_ready & ~flush_req;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_req) begin
      rptr_d = wptr_q;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {s_if_res_data, s_if_res_msg};
  end

endmodule

// File: tb/tb_panda_risc_v_inst_buf.sv
// Scoreboard bench for panda_risc_v_inst_buf. A queue holds the expected buffer
// contents, and a negedge monitor checks the flags and the head word against it.
module tb_panda_risc_v_inst_buf;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush_req = 1'b0;
  logic [127:0] s_if_res_data = '0;
  logic [3:0]   s_if_res_msg = '0;
  logic         s_if_res_valid = 1'b0;
  logic         s_if_res_ready;
  logic [127:0] m_inst_data;
  logic [3:0]   m_inst_msg;
  logic         m_inst_valid;
  logic         m_inst_ready = 1'b0;
  logic [4:0]   inst_buf_cnt;
  logic         inst_buf_empty;
  logic         inst_buf_full;

  panda_risc_v_inst_buf #(.inst_buf_depth(DEPTH), .simulation_delay(1)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req),
    .s_if_res_data(s_if_res_data), .s_if_res_msg(s_if_res_msg),
    .s_if_res_valid(s_if_res_valid), .s_if_res_ready(s_if_res_ready),
    .m_inst_data(m_inst_data), .m_inst_msg(m_inst_msg),
    .m_inst_valid(m_inst_valid), .m_inst_ready(m_inst_ready),
    .inst_buf_cnt(inst_buf_cnt), .inst_buf_empty(inst_buf_empty),
    .inst_buf_full(inst_buf_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   m;
  } item_t;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_pops = 0;
  bit    seen_100 = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // The reference model updates at the clock edge using the inputs the bench is holding.
  always @(posedge clk) begin
    if (!rst) begin
      bit push, pop;
      push = s_if_res_valid && (sb.size() < DEPTH) && !flush_req;
      pop  = m_inst_ready && (sb.size() > 0) && !flush_req;
      if (flush_req) sb.delete();
      else begin
        if (pop) begin
          void'(sb.pop_front());
          n_pops++;
        end
        if (push) sb.push_back('{d: s_if_res_data, m: s_if_res_msg});
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", {127'b0, m_inst_valid}, {127'b0, sb.size() != 0});
    chk("ready", {127'b0, s_if_res_ready}, {127'b0, sb.size() < DEPTH});
    chk("cnt", {123'b0, inst_buf_cnt}, 128'(sb.size()));
    chk("empty", {127'b0, inst_buf_empty}, {127'b0, sb.size() == 0});
    chk("full", {127'b0, inst_buf_full}, {127'b0, sb.size() == DEPTH});
    if (m_inst_valid && sb.size() > 0) begin
      chk("head_data", m_inst_data, sb[0].d);
      chk("head_msg", {124'b0, m_inst_msg}, {124'b0, sb[0].m});
    end
    if (m_inst_valid && m_inst_data[127:96] == 32'h100) seen_100 = 1'b1;
  end

  task automatic cycle(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
    s_if_res_valid = v;
    s_if_res_data  = {pc, $urandom, $urandom, 32'h0000_0013};
    s_if_res_msg   = 4'($urandom);
    m_inst_ready   = rdy;
    flush_req      = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {127'b0, m_inst_valid}, 128'd0);
    chk({tag, "_ready"}, {127'b0, s_if_res_ready}, 128'd1);
    chk({tag, "_cnt"}, {123'b0, inst_buf_cnt}, 128'd0);
    chk({tag, "_empty"}, {127'b0, inst_buf_empty}, 128'd1);
    chk({tag, "_full"}, {127'b0, inst_buf_full}, 128'd0);
    chk({tag, "_data"}, m_inst_data, 128'd0);
    chk({tag, "_msg"}, {124'b0, m_inst_msg}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // First push is visible the next cycle.
    cycle(1, 32'h0, 0, 0);
    chk("first_cnt", {123'b0, inst_buf_cnt}, 128'd1);
    chk("first_pc", {96'b0, m_inst_data[127:96]}, 128'h0);
    cycle(0, 0, 1, 0);

    // Fill with decode stalled, offer a 5th word, then drain.
    for (int i = 0; i < 4; i++) cycle(1, 32'(i * 4), 0, 0);
    chk("fill_full", {127'b0, inst_buf_full}, 128'd1);
    cycle(1, 32'h10, 0, 0);
    chk("fill_cnt", {123'b0, inst_buf_cnt}, 128'd4);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

    // Continuous streaming across two pointer wraps.
    for (int i = 0; i < 20; i++) begin
      cycle(1, 32'h1000 + 32'(i * 4), 1, 0);
      chk("stream_cnt_le1", {127'b0, inst_buf_cnt <= 5'd1}, 128'd1);
    end
    cycle(0, 0, 1, 0);

    // Flush with 3 entries and a word on offer.
    for (int i = 0; i < 3; i++) cycle(1, 32'h40 + 32'(i * 4), 0, 0);
    cycle(1, 32'h100, 0, 1);
    chk("flush_cnt", {123'b0, inst_buf_cnt}, 128'd0);
    chk("flush_valid", {127'b0, m_inst_valid}, 128'd0);
    cycle(1, 32'h200, 0, 0);
    chk("after_flush_cnt", {123'b0, inst_buf_cnt}, 128'd1);
    chk("after_flush_pc", {96'b0, m_inst_data[127:96]}, 128'h200);
    cycle(0, 0, 1, 0);

    // Full, with a pop and an offer in the same cycle.
    for (int i = 0; i < 4; i++) cycle(1, 32'h300 + 32'(i * 4), 0, 0);
    cycle(1, 32'h310, 1, 0);
    chk("fullpop_cnt", {123'b0, inst_buf_cnt}, 128'd3);
    cycle(1, 32'h310, 0, 0);
    chk("fullpop_push_cnt", {123'b0, inst_buf_cnt}, 128'd4);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom | 32'h1,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));

    // Async reset between edges while holding two entries.
    cycle(0, 0, 1, 1);
    cycle(1, 32'h500, 0, 0);
    cycle(1, 32'h504, 0, 0);
    s_if_res_valid = 1'b0;
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1, 32'h0, 0, 0);
    chk("post_rst_cnt", {123'b0, inst_buf_cnt}, 128'd1);
    chk("post_rst_pc", {96'b0, m_inst_data[127:96]}, 128'h0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);

    chk("pc_0x100_never_out", {127'b0, seen_100}, 128'd0);
    chk("pops_happened", {127'b0, n_pops > 20}, 128'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
